modbus_frame_rx: RTL

//  Modbus RTU request receiver: upstream of the response transmitter.

---
 rtl/modbus_frame_rx_pkg.sv | 45 ++++
 rtl/modbus_frame_rx_crc16.sv | 29 ++
 rtl/modbus_frame_rx.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/modbus_frame_rx_pkg.sv
// Shared definitions for the Modbus RTU request receiver and its CRC block.
// Holds state encodings, frame constants, the per-byte CRC step and silence timing.
package modbus_frame_rx_pkg;

  typedef enum logic [1:0] {
    ST_WAIT_IDLE,
    ST_IDLE,
    ST_RECV,
    ST_CHECK
  } rx_state_e;

  localparam logic [3:0]  MB_FRAME_LEN = 4'd8;
  localparam logic [3:0]  MB_CNT_OVER  = 4'd9;
  localparam logic [15:0] CRC_INIT     = 16'hFFFF;
  localparam logic [15:0] CRC_POLY     = 16'hA001;

  localparam logic [7:0] FC_READ_HOLDING = 8'h03;
  localparam logic [7:0] FC_READ_INPUT   = 8'h04;
  localparam logic [7:0] FC_WRITE_SINGLE = 8'h06;

  // Reflected CRC-16/MODBUS, one whole byte folded in per call.
  function automatic logic [15:0] crc16_next(input logic [15:0] crc, input logic [7:0] data);
    logic [15:0] c;
    c = crc ^ {8'h00, data};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
    end
    return c;
  endfunction

  // Silence threshold in clocks; above 19200 baud Modbus fixes the gap in microseconds.
  function automatic logic [31:0] silence_cycles(input int unsigned clk_freq,
                                                 input int unsigned baud_rate,
                                                 input int unsigned half_chars,
                                                 input int unsigned fixed_us);
    longint unsigned cyc;
    if (baud_rate > 32'd19200) begin
      cyc = longint'(clk_freq) * longint'(fixed_us) / 64'd1000000;
    end else begin
      cyc = longint'(clk_freq) * longint'(half_chars) * 64'd11 / (64'd2 * longint'(baud_rate));
    end
    return 32'(cyc);
  endfunction

endpackage

// File: rtl/modbus_frame_rx_crc16.sv
// CRC-16/MODBUS accumulator: one byte per clock, synchronous re-init.
// Shared with the response-side CRC generator.
module crc16_modbus
  import modbus_frame_rx_pkg::*;
(
  input  logic        clk_in,
  input  logic        rst_n_in,
  input  logic        i_init,
  input  logic        i_byte_en,
  input  logic [7:0]  i_data,
  output logic [15:0] o_crc
);

  logic [15:0] r_crc;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_crc <= CRC_INIT;
    end else if (i_init) begin
      r_crc <= CRC_INIT;
    end else if (i_byte_en) begin
      r_crc <= crc16_next(r_crc, i_data);
    end
  end

  assign o_crc = r_crc;

endmodule

// File: rtl/modbus_frame_rx.sv
// Modbus RTU request receiver: frames bytes by t3.5 silence, checks t1.5 gaps,
// slave address and CRC, and strobes decoded fields to the register logic.
module modbus_frame_rx
  import modbus_frame_rx_pkg::*;
#(
  parameter int unsigned CLK_FREQ  = 50_000_000,
  parameter int unsigned BAUD_RATE = 9600,
  parameter logic [7:0]  SADDR     = 8'h01
) (
  input  logic        clk_in,
  input  logic        rst_n_in,
  input  logic        i_rx_drdy,
  input  logic [7:0]  i_rx_data,
  input  logic        i_tx_busy,
  output logic        o_frame_valid,
  output logic [7:0]  o_rx_func_code,
  output logic [15:0] o_rx_reg_addr,
  output logic [15:0] o_rx_quantity,
  output logic        o_crc_err
);

  localparam logic [31:0] T15 = silence_cycles(CLK_FREQ, BAUD_RATE, 3, 750);
  localparam logic [31:0] T35 = silence_cycles(CLK_FREQ, BAUD_RATE, 7, 1750);

  rx_state_e   r_state, w_state_next;
  logic [31:0] r_silence;
  logic [3:0]  r_cnt, w_cnt_next;
  logic        r_bad, w_bad_next;
  logic        r_pend_vld, w_pend_vld_next;
  logic [7:0]  r_pend_data;
  logic [7:0]  r_buf [8];

  logic        r_frame_valid, r_crc_err;
  logic [7:0]  r_func_code;
  logic [15:0] r_reg_addr, r_quantity;

  logic        w_accept, w_sil_t35, w_sil_t15_ok;
  logic        w_byte_vld, w_store, w_crc_init, w_good, w_crc_bad;
  logic [7:0]  w_byte_data;
  logic [15:0] w_crc;

  assign w_accept     = i_rx_drdy & ~i_tx_busy;
  assign w_sil_t35    = (r_silence >= T35);
  assign w_sil_t15_ok = (r_silence <= T15);

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_silence <= '0;
    end else if (w_accept) begin
      r_silence <= '0;
    end else if (!w_sil_t35) begin
      r_silence <= r_silence + 32'd1;
    end
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    w_state_next    = r_state;
    w_cnt_next      = r_cnt;
    w_bad_next      = r_bad;
    w_pend_vld_next = r_pend_vld;
    w_byte_vld      = 1'b0;
    w_byte_data     = i_rx_data;
    w_store         = 1'b0;
    w_crc_init      = 1'b0;
    w_good          = 1'b0;
    w_crc_bad       = 1'b0;
    case (r_state)
      ST_WAIT_IDLE: begin
        if (w_sil_t35 && !w_accept) w_state_next = ST_IDLE;
      end
      ST_IDLE: begin
        w_byte_vld      = r_pend_vld | w_accept;
        w_pend_vld_next = 1'b0;
        if (r_pend_vld) w_byte_data = r_pend_data;
        if (w_byte_vld) begin
          w_store      = 1'b1;
          w_cnt_next   = 4'd1;
          w_state_next = ST_RECV;
        end
      end
      ST_RECV: begin
        if (w_sil_t35) begin
          // A byte landing on the t3.5 edge opens the next frame once CHECK is done.
          w_state_next = ST_CHECK;
          if (w_accept) w_pend_vld_next = 1'b1;
        end else begin
          if (i_tx_busy) w_bad_next = 1'b1;
          if (w_accept) begin
            w_byte_vld = 1'b1;
            w_store    = (r_cnt < MB_FRAME_LEN);
            if (r_cnt != MB_CNT_OVER) w_cnt_next = r_cnt + 4'd1;
            if (!w_sil_t15_ok) w_bad_next = 1'b1;
          end
        end
      end
      ST_CHECK: begin
        w_crc_init   = 1'b1;
        w_cnt_next   = 4'd0;
        w_bad_next   = 1'b0;
        w_state_next = ST_IDLE;
        if (w_accept) w_pend_vld_next = 1'b1;
        if ((r_cnt == MB_FRAME_LEN) && !r_bad && (r_buf[0] == SADDR)) begin
          if (w_crc != 16'h0000) w_crc_bad = 1'b1;
          else                   w_good    = 1'b1;
        end
      end
      default: w_state_next = ST_WAIT_IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_state       <= ST_WAIT_IDLE;
      r_cnt         <= 4'd0;
      r_bad         <= 1'b0;
      r_pend_vld    <= 1'b0;
      r_pend_data   <= 8'h00;
      r_frame_valid <= 1'b0;
      r_crc_err     <= 1'b0;
      r_func_code   <= 8'h00;
      r_reg_addr    <= 16'h0000;
      r_quantity    <= 16'h0000;
    end else begin
      r_state       <= w_state_next;
      r_cnt         <= w_cnt_next;
      r_bad         <= w_bad_next;
      r_pend_vld    <= w_pend_vld_next;
      r_frame_valid <= w_good;
      r_crc_err     <= w_crc_bad;
      if (w_pend_vld_next && !r_pend_vld) r_pend_data <= i_rx_data;
      if (w_good) begin
        r_func_code <= r_buf[1];
        r_reg_addr  <= {r_buf[2], r_buf[3]};
        r_quantity  <= {r_buf[4], r_buf[5]};
      end
    end
  end

  // NOTE: the frame buffer is not reset; CHECK only reads it after all eight slots were written.
  always_ff @(posedge clk_in) begin
    if (w_store) r_buf[r_cnt[2:0]] <= w_byte_data;
  end

  crc16_modbus u_crc (
    .clk_in    (clk_in),
    .rst_n_in  (rst_n_in),
    .i_init    (w_crc_init),
    .i_byte_en (w_byte_vld),
    .i_data    (w_byte_data),
    .o_crc     (w_crc)
  );

  assign o_frame_valid  = r_frame_valid;
  assign o_crc_err      = r_crc_err;
  assign o_rx_func_code = r_func_code;
  assign o_rx_reg_addr  = r_reg_addr;
  assign o_rx_quantity  = r_quantity;

endmodule
